encrypt_seq: RTL and testbench
==============================

ENCRYPT_SEQ -- requirements
Module: encrypt_seq

Interface
REQ-001 SHALL have parameter Q, default 17, the coefficient modulus.
REQ-002 SHALL have parameter QHALF, default 9, the value subtracted per set message bit.
REQ-003 SHALL have parameter TIMEOUT, default 255, the maximum cycles spent in WAIT (timeout build only).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  request one encryption; sampled only in IDLE.
REQ-007 SHALL have port msg  input  4  message bits; latched on accepted start.
REQ-008 SHALL have port e1  input  256  2x4 signed 32-bit noise, word [i*4+j] at bits 32*(i*4+j); latched on accepted start.
REQ-009 SHALL have port e2  input  128  4 signed 32-bit noise words; latched on accepted start.
REQ-010 SHALL have port mul_req  output  1  one-cycle pulse launching the shared polynomial multiplier.
REQ-011 SHALL have port a_sel  output  3  multiplier operand-A select: 0-3 = transposed A row, 4-5 = t row.
REQ-012 SHALL have port r_sel  output  1  multiplier operand-B select: r[0] or r[1].
REQ-013 SHALL have port mul_ack  input  1  multiplier result valid, one cycle.
REQ-014 SHALL have port mul_result  input  128  4 signed 32-bit product coefficients, valid with mul_ack.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse when u and v are valid.
REQ-017 SHALL have port u  output  256  2x4 ciphertext u, each word in [0,Q-1].
REQ-018 SHALL have port v  output  128  4-word ciphertext v, each word in [0,Q-1].
REQ-019 SHALL have port err  output  1  sticky multiplier timeout flag.

Function
REQ-020 SHALL implement states IDLE, ISSUE, WAIT, FINAL, DONE.
REQ-021 Transitions SHALL be: IDLE->ISSUE on start; ISSUE->WAIT unconditionally; WAIT->ISSUE on mul_ack with job<5; WAIT->FINAL on mul_ack with job=5; FINAL->DONE; DONE->IDLE.
REQ-022 Job counter SHALL run 0..5, mapping (a_sel,r_sel,accumulator): 0=(0,0,U0) 1=(1,1,U0) 2=(2,0,U1) 3=(3,1,U1) 4=(4,0,V) 5=(5,1,V).
REQ-023 mul_req SHALL be high exactly one cycle, in ISSUE; a_sel/r_sel SHALL hold stable from ISSUE until the mul_ack cycle.
REQ-024 On mul_ack in WAIT, each coefficient SHALL update acc=mod(acc+mul_result), mod(x) = x%Q plus Q if negative, result in [0,Q-1].
REQ-025 Accumulators SHALL clear to 0 on accepted start.
REQ-026 FINAL SHALL compute u[i][j]=mod(accU_i[j]+e1[i][j]) and v[j]=mod(accV[j]+e2[j]-(msg[3-j]?QHALF:0)), registered.
REQ-027 done SHALL pulse in DONE; u and v SHALL hold until the next FINAL or reset.
REQ-028 Intermediate arithmetic SHALL be 34-bit signed so no overflow occurs before reduction.
REQ-029 start while busy SHALL be ignored; mul_ack outside WAIT SHALL be ignored.
REQ-030 Latency with ack k cycles after mul_req (k>=1) SHALL be 3+6*(k+1) cycles from start to done.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, job=0, accumulators, latched inputs, u, v = 0 and mul_req, busy, done, err = 0, including mid-operation.
REQ-032 After reset release, the first start SHALL behave as a fresh encryption.

Configuration
REQ-033 Macro ENCRYPT_SEQ_TIMEOUT_EN defined: a counter SHALL count WAIT cycles; reaching TIMEOUT without mul_ack SHALL set err, return to IDLE, suppress done; err clears only on reset.
REQ-034 Macro ENCRYPT_SEQ_TIMEOUT_EN undefined: WAIT SHALL last indefinitely and err SHALL be tied 0.

Verification
REQ-035 msg=4'b1111, e1=0, e2=0, all mul_result=0 -> u all 0, v all 8, done one pulse.
REQ-036 mul_result=10 every job, e1=1, e2=16, msg=0 -> u all 4, v all 2.
REQ-037 mul_result=-5 every job, e1=0, e2=0, msg=4'b0001 -> u all 7; v=[7,7,7,15].
REQ-038 Ack 1 cycle after each req -> done exactly 15 cycles after start; start pulses while busy and mul_ack in IDLE produce no effect.
REQ-039 rst_n asserted during job 3 WAIT -> all outputs 0 next cycle; subsequent start completes normally with correct values.
REQ-040 ENCRYPT_SEQ_TIMEOUT_EN defined, no mul_ack -> err=1 after 255 WAIT cycles, busy=0, done never asserted.

Source files
------------

// File: rtl/encrypt_seq_if.sv
// Bundle between encrypt_seq and its environment: host request/response and the
// shared polynomial-multiplier handshake. The master side is the host plus multiplier.
interface encrypt_seq_if;
  logic         start;
  logic [3:0]   msg;
  logic [255:0] e1;
  logic [127:0] e2;
  logic         mul_req;
  logic [2:0]   a_sel;
  logic         r_sel;
  logic         mul_ack;
  logic [127:0] mul_result;
  logic         busy;
  logic         done;
  logic [255:0] u;
  logic [127:0] v;
  logic         err;

  modport master (
    output start, msg, e1, e2, mul_ack, mul_result,
    input  mul_req, a_sel, r_sel, busy, done, u, v, err
  );

  modport slave (
    input  start, msg, e1, e2, mul_ack, mul_result,
    output mul_req, a_sel, r_sel, busy, done, u, v, err
  );
endinterface

// File: rtl/encrypt_seq.sv
// Sequencer for encryption: six multiplier jobs accumulated mod Q, then noise/message add.
// Optional multiplier-timeout watchdog enabled by defining ENCRYPT_SEQ_TIMEOUT_EN.
module encrypt_seq #(
  parameter int unsigned Q       = 17,
  parameter int unsigned QHALF   = 9,
  parameter int unsigned TIMEOUT = 255
) (
  input logic          clk,
  input logic          rst_n,
  encrypt_seq_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StFinal, StDone} state_e;

  localparam logic signed [33:0] QS = 34'(Q);
  localparam logic signed [33:0] QH = 34'(QHALF);

  state_e            state_q, state_d;
  logic [2:0]        job_q, job_d;
  // Words 0-3 accumulate U0, 4-7 U1, 8-11 V; job[2:1] picks the group.
  logic [11:0][31:0] acc_q, acc_d;
  logic [3:0]        msg_q, msg_d;
  logic [7:0][31:0]  e1_q, e1_d, u_q, u_d;
  logic [3:0][31:0]  e2_q, e2_d, v_q, v_d;
  logic signed [33:0] t;
`ifdef ENCRYPT_SEQ_TIMEOUT_EN
  logic [31:0]       tmo_q, tmo_d;
  logic              err_q, err_d;
`endif

  function automatic logic signed [33:0] sx(input logic [31:0] w);
    return {{2{w[31]}}, w};
  endfunction

  function automatic logic signed [33:0] zx(input logic [31:0] w);
    return {2'b00, w};
  endfunction

  function automatic logic [31:0] mod_q(input logic signed [33:0] x);
    logic signed [33:0] r;
    r = x % QS;
    if (r < 0) r = r + QS;
    return 32'(r);
  endfunction

  always_comb begin
    state_d = state_q;
    job_d   = job_q;
    acc_d   = acc_q;
    msg_d   = msg_q;
    e1_d    = e1_q;
    e2_d    = e2_q;
    u_d     = u_q;
    v_d     = v_q;
    t       = '0;
`ifdef ENCRYPT_SEQ_TIMEOUT_EN
    tmo_d   = tmo_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StIssue;
          job_d   = '0;
          acc_d   = '0;
          msg_d   = bus.msg;
          e1_d    = bus.e1;
          e2_d    = bus.e2;
        end
      end
      StIssue: begin
        state_d = StWait;
`ifdef ENCRYPT_SEQ_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      StWait: begin
        if (bus.mul_ack) begin
          for (int j = 0; j < 4; j++) begin
            acc_d[4*int'(job_q[2:1])+j] = mod_q(zx(acc_q[4*int'(job_q[2:1])+j]) +
                                                sx(bus.mul_result[32*j +: 32]));
          end
          if (job_q == 3'd5) begin
            state_d = StFinal;
          end else begin
            job_d   = job_q + 3'd1;
            state_d = StIssue;
          end
        end
`ifdef ENCRYPT_SEQ_TIMEOUT_EN
        else if (tmo_q == TIMEOUT - 1) begin
          err_d   = 1'b1;
          job_d   = '0;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
`endif
      end
      StFinal: begin
        for (int j = 0; j < 4; j++) begin
          for (int i = 0; i < 2; i++) begin
            u_d[i*4+j] = mod_q(zx(acc_q[i*4+j]) + sx(e1_q[i*4+j]));
          end
          t = zx(acc_q[8+j]) + sx(e2_q[j]);
          if (msg_q[3-j]) t = t - QH;
          v_d[j] = mod_q(t);
        end
        job_d   = '0;
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      job_q   <= '0;
      acc_q   <= '0;
      msg_q   <= '0;
      e1_q    <= '0;
      e2_q    <= '0;
      u_q     <= '0;
      v_q     <= '0;
`ifdef ENCRYPT_SEQ_TIMEOUT_EN
      tmo_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      job_q   <= job_d;
      acc_q   <= acc_d;
      msg_q   <= msg_d;
      e1_q    <= e1_d;
      e2_q    <= e2_d;
      u_q     <= u_d;
      v_q     <= v_d;
`ifdef ENCRYPT_SEQ_TIMEOUT_EN
      tmo_q   <= tmo_d;
      err_q   <= err_d;
`endif
    end
  end

  // Selects come straight from the job counter, so they stay put from ISSUE through the ack.
  assign bus.mul_req = (state_q == StIssue);
  assign bus.a_sel   = job_q;
  assign bus.r_sel   = job_q[0];
  assign bus.busy    = (state_q != StIdle);
  assign bus.done    = (state_q == StDone);
  assign bus.u       = u_q;
  assign bus.v       = v_q;
`ifdef ENCRYPT_SEQ_TIMEOUT_EN
  assign bus.err     = err_q;
`else
  assign bus.err     = 1'b0;
`endif

endmodule

// File: tb/tb_encrypt_seq.sv
// Randomized bench for encrypt_seq with a multiplier responder and a sum-then-reduce
// reference model of the ciphertext.
module tb_encrypt_seq;
  localparam int Q       = 17;
  localparam int QHALF   = 9;
  localparam int TIMEOUT = 255;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  encrypt_seq_if bus ();
  encrypt_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0;
  int n_pass = 0;

  logic [127:0] res [6];
  logic [3:0]   sel_req [6];
  logic [3:0]   sel_ack [6];
  int req_idx = 0;
  int ack_k   = 1;
  int rst_gen = 0;
  bit resp_en = 1'b1;
  bit stray_ack = 1'b0;

  function automatic longint md(input longint x);
    longint r;
    r = x % Q;
    if (r < 0) r = r + Q;
    return r;
  endfunction

  function automatic longint w4(input logic [127:0] x, input int j);
    logic [31:0] t;
    t = x[32*j +: 32];
    return longint'($signed(t));
  endfunction

  function automatic longint w8(input logic [255:0] x, input int j);
    logic [31:0] t;
    t = x[32*j +: 32];
    return longint'($signed(t));
  endfunction

  function automatic logic [127:0] rnd128();
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Each ciphertext word is the plain sum of its two products plus noise, reduced once.
  task automatic model(input logic [3:0] m, input logic [255:0] a, input logic [127:0] b,
                       output logic [255:0] eu, output logic [127:0] ev);
    longint s;
    eu = '0;
    ev = '0;
    for (int g = 0; g < 3; g++) begin
      for (int j = 0; j < 4; j++) begin
        s = w4(res[2*g], j) + w4(res[2*g+1], j);
        if (g < 2) eu[32*(g*4+j) +: 32] = 32'(md(s + w8(a, g*4+j)));
        else ev[32*j +: 32] = 32'(md(s + w4(b, j) - (m[3-j] ? longint'(QHALF) : 64'sd0)));
      end
    end
  endtask

  // Multiplier stand-in: acks k cycles after each request with res[job].
  initial begin
    int idx;
    int gen;
    bus.mul_ack    = 1'b0;
    bus.mul_result = '0;
    forever begin
      @(posedge clk); #1;
      bus.mul_ack = 1'b0;
      if (stray_ack) begin
        bus.mul_ack    = 1'b1;
        bus.mul_result = {4{32'd3}};
        stray_ack      = 1'b0;
      end else if (bus.mul_req && rst_n) begin
        idx = req_idx;
        gen = rst_gen;
        if (idx < 6) sel_req[idx] = {bus.r_sel, bus.a_sel};
        req_idx++;
        if (resp_en) begin
          repeat (ack_k) begin @(posedge clk); #1; end
          if (rst_n && gen == rst_gen && idx < 6) begin
            bus.mul_ack    = 1'b1;
            bus.mul_result = res[idx];
            sel_ack[idx]   = {bus.r_sel, bus.a_sel};
          end
        end
      end
    end
  end

  task automatic run_enc(input logic [3:0] m, input logic [255:0] a, input logic [127:0] b,
                         input int k, input bit spam, output int lat, output int ndone);
    int cyc;
    bit seen;
    req_idx = 0;
    ack_k   = k;
    lat     = -1;
    ndone   = 0;
    seen    = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sel_req[i] = 4'hF;
      sel_ack[i] = 4'hF;
    end
    bus.msg   = m;
    bus.e1    = a;
    bus.e2    = b;
    bus.start = 1'b1;
    cyc = 0;
    while (cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      bus.start = 1'b0;
      if (spam && bus.busy && !bus.done) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.msg   = 4'($urandom);
        bus.e1    = rnd256();
        bus.e2    = rnd128();
      end
      if (bus.done) begin
        ndone++;
        if (!seen) lat = cyc + 1;
        seen = 1'b1;
      end
      if (seen && !bus.busy) break;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", bus.busy);
    else n_pass++;
    n_chk++; if (bus.done !== 1'b0) $display("FAIL reset_done got=%0b exp=0", bus.done);
    else n_pass++;
    n_chk++; if (bus.mul_req !== 1'b0) $display("FAIL reset_mul_req got=%0b exp=0", bus.mul_req);
    else n_pass++;
    n_chk++; if (bus.err !== 1'b0) $display("FAIL reset_err got=%0b exp=0", bus.err);
    else n_pass++;
    n_chk++; if (bus.u !== 256'd0) $display("FAIL reset_u got=%h exp=0", bus.u);
    else n_pass++;
    n_chk++; if (bus.v !== 128'd0) $display("FAIL reset_v got=%h exp=0", bus.v);
    else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL idle_busy got=%0b exp=0", bus.busy);
    else n_pass++;
  endtask

  task automatic test_directed;
    logic [3:0]   m;
    logic [255:0] a, eu;
    logic [127:0] b, ev;
    logic [31:0]  r;
    int lat, nd;
    for (int c = 0; c < 3; c++) begin
      case (c)
        0: begin m = 4'b1111; a = '0; b = '0; r = 32'd0;
                 eu = '0; ev = {4{32'd8}}; end
        1: begin m = 4'b0000; a = {8{32'd1}}; b = {4{32'd16}}; r = 32'd10;
                 eu = {8{32'd4}}; ev = {4{32'd2}}; end
        default: begin m = 4'b0001; a = '0; b = '0; r = 32'hFFFF_FFFB;
                 eu = {8{32'd7}}; ev = {32'd15, 32'd7, 32'd7, 32'd7}; end
      endcase
      for (int i = 0; i < 6; i++) res[i] = {4{r}};
      run_enc(m, a, b, 1, 1'b0, lat, nd);
      n_chk++; if (bus.u !== eu) $display("FAIL dir%0d_u got=%h exp=%h", c, bus.u, eu);
      else n_pass++;
      n_chk++; if (bus.v !== ev) $display("FAIL dir%0d_v got=%h exp=%h", c, bus.v, ev);
      else n_pass++;
      n_chk++; if (nd !== 1) $display("FAIL dir%0d_done_pulses got=%0d exp=1", c, nd);
      else n_pass++;
      n_chk++; if (lat !== 15) $display("FAIL dir%0d_latency got=%0d exp=15", c, lat);
      else n_pass++;
    end
  endtask

  task automatic test_random;
    logic [3:0]   m;
    logic [255:0] a, eu;
    logic [127:0] b, ev;
    logic [3:0]   es;
    int k, lat, nd;
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < 6; i++) res[i] = rnd128();
      m = 4'($urandom);
      a = rnd256();
      b = rnd128();
      k = $urandom_range(1, 4);
      model(m, a, b, eu, ev);
      run_enc(m, a, b, k, 1'b0, lat, nd);
      n_chk++; if (bus.u !== eu) $display("FAIL rnd%0d_u got=%h exp=%h", n, bus.u, eu);
      else n_pass++;
      n_chk++; if (bus.v !== ev) $display("FAIL rnd%0d_v got=%h exp=%h", n, bus.v, ev);
      else n_pass++;
      n_chk++; if (nd !== 1) $display("FAIL rnd%0d_done_pulses got=%0d exp=1", n, nd);
      else n_pass++;
      n_chk++;
      if (lat !== 3 + 6 * (k + 1)) $display("FAIL rnd%0d_latency got=%0d exp=%0d", n, lat,
                                            3 + 6 * (k + 1));
      else n_pass++;
      for (int j = 0; j < 6; j++) begin
        es[2:0] = 3'(j);
        es[3]   = (j % 2 == 1);
        n_chk++;
        if (sel_req[j] !== es) $display("FAIL rnd%0d_sel_req%0d got=%h exp=%h", n, j,
                                        sel_req[j], es);
        else n_pass++;
        n_chk++;
        if (sel_ack[j] !== es) $display("FAIL rnd%0d_sel_ack%0d got=%h exp=%h", n, j,
                                        sel_ack[j], es);
        else n_pass++;
      end
    end
    n_chk++; if (bus.err !== 1'b0) $display("FAIL rnd_err got=%0b exp=0", bus.err);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [3:0]   m;
    logic [255:0] a, eu;
    logic [127:0] b, ev;
    int lat, nd;
    for (int i = 0; i < 6; i++) res[i] = rnd128();
    m = 4'($urandom);
    a = rnd256();
    b = rnd128();
    model(m, a, b, eu, ev);
    run_enc(m, a, b, 1, 1'b1, lat, nd);
    n_chk++; if (bus.u !== eu) $display("FAIL spam_u got=%h exp=%h", bus.u, eu);
    else n_pass++;
    n_chk++; if (bus.v !== ev) $display("FAIL spam_v got=%h exp=%h", bus.v, ev);
    else n_pass++;
    n_chk++; if (nd !== 1) $display("FAIL spam_done_pulses got=%0d exp=1", nd);
    else n_pass++;
    n_chk++; if (lat !== 15) $display("FAIL spam_latency got=%0d exp=15", lat);
    else n_pass++;
    stray_ack = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL stray_ack_busy got=%0b exp=0", bus.busy);
    else n_pass++;
    n_chk++; if (bus.u !== eu) $display("FAIL stray_ack_u got=%h exp=%h", bus.u, eu);
    else n_pass++;
    n_chk++; if (bus.v !== ev) $display("FAIL stray_ack_v got=%h exp=%h", bus.v, ev);
    else n_pass++;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 6; i++) res[i] = rnd128();
      m = 4'($urandom);
      a = rnd256();
      b = rnd128();
      model(m, a, b, eu, ev);
      run_enc(m, a, b, 2, 1'b0, lat, nd);
      n_chk++; if (bus.u !== eu) $display("FAIL b2b%0d_u got=%h exp=%h", r, bus.u, eu);
      else n_pass++;
      n_chk++; if (bus.v !== ev) $display("FAIL b2b%0d_v got=%h exp=%h", r, bus.v, ev);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid;
    logic [3:0]   m;
    logic [255:0] a, eu;
    logic [127:0] b, ev;
    int cyc, lat, nd;
    for (int i = 0; i < 6; i++) res[i] = rnd128();
    req_idx   = 0;
    ack_k     = 3;
    bus.msg   = 4'($urandom);
    bus.e1    = rnd256();
    bus.e2    = rnd128();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 0;
    while (req_idx < 4 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_chk++; if (req_idx < 4) $display("FAIL mid_reach_job3 got=%0d exp>=4", req_idx);
    else n_pass++;
    @(posedge clk); #1;
    n_chk++; if (bus.busy !== 1'b1) $display("FAIL mid_busy_pre got=%0b exp=1", bus.busy);
    else n_pass++;
    rst_n = 1'b0;
    rst_gen++;
    #1;
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL mid_rst_busy got=%0b exp=0", bus.busy);
    else n_pass++;
    n_chk++; if (bus.done !== 1'b0) $display("FAIL mid_rst_done got=%0b exp=0", bus.done);
    else n_pass++;
    n_chk++; if (bus.mul_req !== 1'b0) $display("FAIL mid_rst_req got=%0b exp=0", bus.mul_req);
    else n_pass++;
    n_chk++; if (bus.a_sel !== 3'd0) $display("FAIL mid_rst_a_sel got=%0d exp=0", bus.a_sel);
    else n_pass++;
    n_chk++; if (bus.u !== 256'd0) $display("FAIL mid_rst_u got=%h exp=0", bus.u);
    else n_pass++;
    n_chk++; if (bus.v !== 128'd0) $display("FAIL mid_rst_v got=%h exp=0", bus.v);
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) res[i] = rnd128();
    m = 4'($urandom);
    a = rnd256();
    b = rnd128();
    model(m, a, b, eu, ev);
    run_enc(m, a, b, 2, 1'b0, lat, nd);
    n_chk++; if (bus.u !== eu) $display("FAIL post_rst_u got=%h exp=%h", bus.u, eu);
    else n_pass++;
    n_chk++; if (bus.v !== ev) $display("FAIL post_rst_v got=%h exp=%h", bus.v, ev);
    else n_pass++;
    n_chk++; if (lat !== 21) $display("FAIL post_rst_latency got=%0d exp=21", lat);
    else n_pass++;
  endtask

`ifdef ENCRYPT_SEQ_TIMEOUT_EN
  task automatic test_timeout;
    int busy_cnt, done_cnt, cyc;
    resp_en   = 1'b0;
    req_idx   = 0;
    bus.start = 1'b1;
    busy_cnt  = 0;
    done_cnt  = 0;
    cyc       = 0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    while (bus.busy && cyc < 400) begin
      busy_cnt++;
      if (bus.done) done_cnt++;
      @(posedge clk); #1;
      cyc++;
    end
    n_chk++; if (bus.err !== 1'b1) $display("FAIL tmo_err got=%0b exp=1", bus.err);
    else n_pass++;
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL tmo_busy got=%0b exp=0", bus.busy);
    else n_pass++;
    n_chk++; if (done_cnt !== 0) $display("FAIL tmo_done got=%0d exp=0", done_cnt);
    else n_pass++;
    n_chk++;
    if (busy_cnt !== TIMEOUT + 1) $display("FAIL tmo_cycles got=%0d exp=%0d", busy_cnt,
                                           TIMEOUT + 1);
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (bus.err !== 1'b1) $display("FAIL tmo_sticky got=%0b exp=1", bus.err);
    else n_pass++;
    resp_en = 1'b1;
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.msg   = '0;
    bus.e1    = '0;
    bus.e2    = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
`ifdef ENCRYPT_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
